axi_ddr_responder: RTL and testbench

AXI_DDR_RESPONDER -- requirements
Module: axi_ddr_responder

---
 rtl/axi_ddr_responder_if.sv | 76 +++++++
 rtl/axi_ddr_responder.sv | 193 +++++++++++++++++++
 tb/tb_axi_ddr_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ddr_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_ddr_responder_if
// Description : AXI4 bundle between the SoC DDR master port and the DDR
//               responder. Only address/data/response/handshake fields are
//               carried; prot/region/lock/cache/qos/user are not present.
//   Parameters  : ID_W - width of all ID fields
//   Modports    : master - drives AW/W/AR channels and bready/rready
//                 slave  - drives ready signals plus B and R channels
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_ddr_responder_if #(
  parameter int ID_W = 4
) ();
  // write address channel
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [ID_W-1:0] awid;
  logic            awvalid;
  logic            awready;
  // write data channel
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  // write response channel
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;
  logic            bvalid;
  logic            bready;
  // read address channel
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [ID_W-1:0] arid;
  logic            arvalid;
  logic            arready;
  // read data channel
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic [ID_W-1:0] rid;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rid, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rdata, rresp, rlast, rid, rvalid,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_ddr_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_ddr_responder
// Description : AXI4 slave terminating the SoC DDR master port. A single-port
//               32-bit synchronous memory is shared by reads and writes, and
//               one transaction is in flight at a time. INCR and FIXED bursts
//               of 32-bit beats are served; anything else answers SLVERR,
//               beats beyond the memory answer DECERR.
//   Parameters  : MEM_WORDS - memory depth in 32-bit words (power of two)
//                 ID_W      - width of all ID fields
//   Ports       : clk       - sole clock, rising edge
//                 rst       - synchronous active-high reset
//                 AXI_DDR   - AXI4 bundle, slave side
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ddr_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int ID_W      = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  axi_ddr_responder_if.slave  AXI_DDR
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WDATA = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [2:0]      state_q, state_d;
  logic [31:0]     addr_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [ID_W-1:0] id_q;
  logic            wr_prio_q;   // 1: write wins the next simultaneous request
  logic [1:0]      bresp_q;     // worst response seen over the write burst
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;

  logic [31:0] mem_q [MEM_WORDS];

  logic        grant_w, grant_r;
  logic        last_beat;
  logic        w_beat;
  logic [1:0]  beat_err;
  logic [1:0]  wbeat_resp;
  logic [31:0] next_addr;

  // Contention resolves to the side holding priority; a lone request wins.
  assign grant_w   = AXI_DDR.awvalid && (!AXI_DDR.arvalid || wr_prio_q);
  assign grant_r   = AXI_DDR.arvalid && (!AXI_DDR.awvalid || !wr_prio_q);
  assign last_beat = (cnt_q == len_q);
  assign w_beat    = (state_q == S_WDATA) && AXI_DDR.wvalid;
  assign next_addr = (burst_q == 2'b01) ? addr_q + 32'd4 : addr_q;

  // Per-beat error: address decode outranks the burst/size check.
  always_comb begin
    beat_err = RESP_OKAY;
    if ({1'b0, addr_q} >= MEM_BYTES) begin
      beat_err = RESP_DECERR;
    end else if ((size_q != 3'd2) || burst_q[1]) begin
      beat_err = RESP_SLVERR;
    end
  end

  // A wlast that disagrees with the beat count only downgrades an OKAY beat.
  assign wbeat_resp = ((beat_err == RESP_OKAY) && (AXI_DDR.wlast != last_beat))
                      ? RESP_SLVERR : beat_err;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_w) begin
          state_d = S_WDATA;
        end else if (grant_r) begin
          state_d = S_RADDR;
        end
      end
      S_WDATA: if (AXI_DDR.wvalid && last_beat) state_d = S_WRESP;
      S_WRESP: if (AXI_DDR.bready) state_d = S_IDLE;
      S_RADDR: state_d = S_RDATA;
      S_RDATA: if (AXI_DDR.rready) state_d = last_beat ? S_IDLE : S_RADDR;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    AXI_DDR.awready = (state_q == S_IDLE) && grant_w && !rst;
    AXI_DDR.arready = (state_q == S_IDLE) && !grant_w && grant_r && !rst;
    AXI_DDR.wready  = (state_q == S_WDATA);
    AXI_DDR.bvalid  = (state_q == S_WRESP);
    AXI_DDR.bresp   = (state_q == S_WRESP) ? bresp_q : RESP_OKAY;
    AXI_DDR.bid     = (state_q == S_WRESP) ? id_q : '0;
    AXI_DDR.rvalid  = (state_q == S_RDATA);
    AXI_DDR.rlast   = (state_q == S_RDATA) && last_beat;
    AXI_DDR.rresp   = (state_q == S_RDATA) ? rresp_q : RESP_OKAY;
    AXI_DDR.rid     = (state_q == S_RDATA) ? id_q : '0;
    AXI_DDR.rdata   = rdata_q;
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      id_q      <= '0;
      wr_prio_q <= 1'b1;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_w) begin
            addr_q  <= AXI_DDR.awaddr;
            len_q   <= AXI_DDR.awlen;
            size_q  <= AXI_DDR.awsize;
            burst_q <= AXI_DDR.awburst;
            id_q    <= AXI_DDR.awid;
            cnt_q   <= '0;
            bresp_q <= RESP_OKAY;
            if (AXI_DDR.arvalid) wr_prio_q <= 1'b0;
          end else if (grant_r) begin
            addr_q  <= AXI_DDR.araddr;
            len_q   <= AXI_DDR.arlen;
            size_q  <= AXI_DDR.arsize;
            burst_q <= AXI_DDR.arburst;
            id_q    <= AXI_DDR.arid;
            cnt_q   <= '0;
            if (AXI_DDR.awvalid) wr_prio_q <= 1'b1;
          end
        end
        S_WDATA: begin
          if (AXI_DDR.wvalid) begin
            // Response codes are ordered so the numeric max is the worst.
            if (wbeat_resp > bresp_q) bresp_q <= wbeat_resp;
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr;
          end
        end
        S_RADDR: begin
          rresp_q <= beat_err;
          rdata_q <= (beat_err == RESP_OKAY) ? mem_q[addr_q[AW+1:2]] : 32'd0;
        end
        S_RDATA: begin
          if (AXI_DDR.rready && !last_beat) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory contents survive reset; a beat in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_beat && (beat_err == RESP_OKAY)) begin
      for (int b = 0; b < 4; b++) begin
        if (AXI_DDR.wstrb[b]) begin
          mem_q[addr_q[AW+1:2]][b*8 +: 8] <= AXI_DDR.wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_ddr_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ddr_responder
// Description : Directed self-checking bench for axi_ddr_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ddr_responder;

  localparam int MEM_WORDS = 1024;
  localparam int ID_W      = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  axi_ddr_responder_if #(.ID_W(ID_W)) bus ();

  axi_ddr_responder #(.MEM_WORDS(MEM_WORDS), .ID_W(ID_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .AXI_DDR (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input logic [3:0] id);
    bit ok = 0;
    bus.awaddr = a; bus.awlen = len; bus.awsize = sz; bus.awburst = bt; bus.awid = id;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (bus.awready === 1'b1) ok = 1; else tick();
    end
    chk("aw_handshake", 32'(ok), 32'd1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    bit ok = 0;
    bus.araddr = a; bus.arlen = len; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = id;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (bus.arready === 1'b1) ok = 1; else tick();
    end
    chk("ar_handshake", 32'(ok), 32'd1);
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
    bit ok = 0;
    bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (bus.wready === 1'b1) ok = 1; else tick();
    end
    chk("w_handshake", 32'(ok), 32'd1);
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic get_b(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id);
    bit ok = 0;
    bus.bready = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (bus.bvalid === 1'b1) ok = 1; else tick();
    end
    chk({tag, "_bvalid"}, 32'(ok), 32'd1);
    chk({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
    chk({tag, "_bid"}, 32'(bus.bid), 32'(exp_id));
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic get_r(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                       input logic exp_last, input logic [3:0] exp_id);
    bit ok = 0;
    bus.rready = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (bus.rvalid === 1'b1) ok = 1; else tick();
    end
    chk({tag, "_rvalid"}, 32'(ok), 32'd1);
    chk({tag, "_rdata"}, bus.rdata, exp_data);
    chk({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_resp));
    chk({tag, "_rlast"}, 32'(bus.rlast), 32'(exp_last));
    chk({tag, "_rid"}, 32'(bus.rid), 32'(exp_id));
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic write1(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz, input logic last, input logic [1:0] exp_resp);
    send_aw(a, 8'd0, sz, 2'b01, 4'd1);
    send_w(d, 4'hF, last);
    get_b(tag, exp_resp, 4'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_awready"}, 32'(bus.awready), 32'd0);
    chk({tag, "_arready"}, 32'(bus.arready), 32'd0);
    chk({tag, "_wready"},  32'(bus.wready),  32'd0);
    chk({tag, "_bvalid"},  32'(bus.bvalid),  32'd0);
    chk({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
    chk({tag, "_rlast"},   32'(bus.rlast),   32'd0);
    chk({tag, "_bresp"},   32'(bus.bresp),   32'd0);
    chk({tag, "_rresp"},   32'(bus.rresp),   32'd0);
    chk({tag, "_bid"},     32'(bus.bid),     32'd0);
    chk({tag, "_rid"},     32'(bus.rid),     32'd0);
    chk({tag, "_rdata"},   bus.rdata,        32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awid = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Single write then single read.
    send_aw(32'h10, 8'd0, 3'd2, 2'b01, 4'd3);
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    get_b("single_wr", 2'b00, 4'd3);
    send_ar(32'h10, 8'd0, 4'd5);
    get_r("single_rd", 32'hDEADBEEF, 2'b00, 1'b1, 4'd5);

    // INCR 4-beat burst with a partial strobe on the third beat.
    send_aw(32'h100, 8'd3, 3'd2, 2'b01, 4'd2);
    for (int i = 0; i < 4; i++) send_w(32'hFFFFFFFF, 4'hF, i == 3);
    get_b("fill_wr", 2'b00, 4'd2);
    send_aw(32'h100, 8'd3, 3'd2, 2'b01, 4'd2);
    send_w(32'h11111111, 4'hF, 1'b0);
    send_w(32'h22222222, 4'hF, 1'b0);
    send_w(32'h33334444, 4'h3, 1'b0);
    send_w(32'h55555555, 4'hF, 1'b1);
    get_b("burst_wr", 2'b00, 4'd2);
    send_ar(32'h100, 8'd3, 4'd6);
    get_r("burst_rd0", 32'h11111111, 2'b00, 1'b0, 4'd6);
    get_r("burst_rd1", 32'h22222222, 2'b00, 1'b0, 4'd6);
    get_r("burst_rd2", 32'hFFFF4444, 2'b00, 1'b0, 4'd6);
    get_r("burst_rd3", 32'h55555555, 2'b00, 1'b1, 4'd6);

    // Simultaneous requests: write first, then read first.
    bus.awaddr = 32'h20; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awid = 4'd7;
    bus.araddr = 32'h10; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = 4'd8;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    #1;
    chk("arb1_awready", 32'(bus.awready), 32'd1);
    chk("arb1_arready", 32'(bus.arready), 32'd0);
    tick();
    bus.awvalid = 1'b0;
    #1;
    chk("arb1_ar_blocked", 32'(bus.arready), 32'd0);
    send_w(32'hA5A5A5A5, 4'hF, 1'b1);
    get_b("arb1_wr", 2'b00, 4'd7);
    send_ar(32'h10, 8'd0, 4'd8);
    get_r("arb1_rd", 32'hDEADBEEF, 2'b00, 1'b1, 4'd8);

    bus.awaddr = 32'h24; bus.awid = 4'd9;
    bus.araddr = 32'h20; bus.arid = 4'd10;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    #1;
    chk("arb2_arready", 32'(bus.arready), 32'd1);
    chk("arb2_awready", 32'(bus.awready), 32'd0);
    tick();
    bus.arvalid = 1'b0;
    get_r("arb2_rd", 32'hA5A5A5A5, 2'b00, 1'b1, 4'd10);
    send_aw(32'h24, 8'd0, 3'd2, 2'b01, 4'd9);
    send_w(32'h5A5A5A5A, 4'hF, 1'b1);
    get_b("arb2_wr", 2'b00, 4'd9);

    // Memory end: last word OKAY, the following beat DECERR.
    write1("top_wr", 32'(MEM_WORDS - 1) * 4, 32'hCAFEF00D, 3'd2, 1'b1, 2'b00);
    send_ar(32'(MEM_WORDS - 1) * 4, 8'd1, 4'd4);
    get_r("edge_rd0", 32'hCAFEF00D, 2'b00, 1'b0, 4'd4);
    get_r("edge_rd1", 32'h0, 2'b11, 1'b1, 4'd4);

    // Error writes: bad size, out of range, wlast missing.
    write1("size_wr", 32'h10, 32'h12345678, 3'd1, 1'b1, 2'b10);
    write1("decerr_wr", 32'(MEM_WORDS) * 4, 32'h12345678, 3'd2, 1'b1, 2'b11);
    write1("wlast_wr", 32'h30, 32'h00000077, 3'd2, 1'b0, 2'b10);
    send_ar(32'h10, 8'd0, 4'd1);
    get_r("size_unchanged", 32'hDEADBEEF, 2'b00, 1'b1, 4'd1);
    send_ar(32'h30, 8'd0, 4'd1);
    get_r("wlast_written", 32'h00000077, 2'b00, 1'b1, 4'd1);

    // Backpressure on R and B.
    send_ar(32'h10, 8'd0, 4'd11);
    for (int i = 0; i < 40 && bus.rvalid !== 1'b1; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("rhold_rvalid", 32'(bus.rvalid), 32'd1);
      chk("rhold_rdata", bus.rdata, 32'hDEADBEEF);
      chk("rhold_rresp", 32'(bus.rresp), 32'd0);
      tick();
    end
    get_r("rhold_rd", 32'hDEADBEEF, 2'b00, 1'b1, 4'd11);
    send_aw(32'h40, 8'd0, 3'd2, 2'b01, 4'd12);
    send_w(32'h0BADF00D, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bhold_bvalid", 32'(bus.bvalid), 32'd1);
      chk("bhold_bid", 32'(bus.bid), 32'd12);
      tick();
    end
    get_b("bhold_wr", 2'b00, 4'd12);

    // Reset during a write burst after two beats.
    send_aw(32'h200, 8'd3, 3'd2, 2'b01, 4'd1);
    for (int i = 0; i < 4; i++) send_w(32'h0, 4'hF, i == 3);
    get_b("pre_rst_wr", 2'b00, 4'd1);
    send_aw(32'h200, 8'd3, 3'd2, 2'b01, 4'd13);
    send_w(32'hAAAA0001, 4'hF, 1'b0);
    send_w(32'hAAAA0002, 4'hF, 1'b0);
    rst = 1'b1;
    tick();
    check_idle_outputs("midrst");
    rst = 1'b0;
    tick();
    chk("midrst_no_bvalid", 32'(bus.bvalid), 32'd0);
    send_ar(32'h200, 8'd3, 4'd14);
    get_r("midrst_rd0", 32'hAAAA0001, 2'b00, 1'b0, 4'd14);
    get_r("midrst_rd1", 32'hAAAA0002, 2'b00, 1'b0, 4'd14);
    get_r("midrst_rd2", 32'h0, 2'b00, 1'b0, 4'd14);
    get_r("midrst_rd3", 32'h0, 2'b00, 1'b1, 4'd14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
